divider_scheduler: RTL



---
 rtl/divider_sched_pkg.sv | 19 +
 rtl/divider_scheduler_if.sv | 31 +++
 rtl/serial_divider_core.sv | 84 ++++++++
 rtl/divider_scheduler.sv | 123 ++++++++++++
 4 files changed

// File: rtl/divider_sched_pkg.sv
// Shared types and constants for the divider scheduler and its serial divider core.
package divider_sched_pkg;

   localparam int unsigned DefaultWidth = 16;

   typedef enum logic [2:0] {
      StIdle,
      StAccept,
      StCalc,
      StFinish,
      StResult
   } state_e;

   typedef enum logic {
      GrantA,
      GrantB
   } grant_e;

endpackage

// File: rtl/divider_scheduler_if.sv
// Operand and result stb/ack streams for the two requesters sharing the divider.
interface divider_scheduler_if
   import divider_sched_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
);

   logic [2*WIDTH-1:0] input_a;
   logic               input_a_stb;
   logic               input_a_ack;
   logic [2*WIDTH-1:0] input_b;
   logic               input_b_stb;
   logic               input_b_ack;
   logic [2*WIDTH-1:0] output_a;
   logic               output_a_stb;
   logic               output_a_ack;
   logic [2*WIDTH-1:0] output_b;
   logic               output_b_stb;
   logic               output_b_ack;

   modport master (
      output input_a, input_a_stb, input_b, input_b_stb, output_a_ack, output_b_ack,
      input  input_a_ack, input_b_ack, output_a, output_a_stb, output_b, output_b_stb
   );

   modport slave (
      input  input_a, input_a_stb, input_b, input_b_stb, output_a_ack, output_b_ack,
      output input_a_ack, input_b_ack, output_a, output_a_stb, output_b, output_b_stb
   );

endinterface

// File: rtl/serial_divider_core.sv
// Signed restoring divider: one quotient bit per calc cycle on operand magnitudes, C-style signs.
module serial_divider_core
   import divider_sched_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_i,
   input  logic             calc_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             done_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o
);

   localparam int unsigned CntW = $clog2(WIDTH);

   logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d, dvd_q, dvd_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d, zero_q, zero_d;
   logic [WIDTH:0]   trial;

   always_comb begin
      quo_d     = quo_q;
      rem_d     = rem_q;
      dvs_d     = dvs_q;
      dvd_d     = dvd_q;
      cnt_d     = cnt_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      zero_d    = zero_q;
      // quo_q doubles as the dividend shift register; its MSB feeds the partial remainder
      trial     = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};
      if (start_i) begin
         quo_d     = dividend_i[WIDTH-1] ? -dividend_i : dividend_i;
         dvs_d     = divisor_i[WIDTH-1] ? -divisor_i : divisor_i;
         rem_d     = '0;
         dvd_d     = dividend_i;
         cnt_d     = CntW'(WIDTH - 1);
         neg_quo_d = dividend_i[WIDTH-1] ^ divisor_i[WIDTH-1];
         neg_rem_d = dividend_i[WIDTH-1];
         zero_d    = (divisor_i == '0);
      end else if (calc_i) begin
         cnt_d = cnt_q - CntW'(1);
         if (!trial[WIDTH]) begin
            rem_d = trial[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
         end else begin
            rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         quo_q     <= '0;
         rem_q     <= '0;
         dvs_q     <= '0;
         dvd_q     <= '0;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         zero_q    <= 1'b0;
      end else begin
         quo_q     <= quo_d;
         rem_q     <= rem_d;
         dvs_q     <= dvs_d;
         dvd_q     <= dvd_d;
         cnt_q     <= cnt_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         zero_q    <= zero_d;
      end
   end

   assign done_o      = calc_i && (cnt_q == '0);
   // Divide-by-zero result is forced regardless of what the shift/subtract loop produced
   assign quotient_o  = zero_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
   assign remainder_o = zero_q ? dvd_q : (neg_rem_q ? -rem_q : rem_q);

endmodule

// File: rtl/divider_scheduler.sv
// Round-robin sharing of one serial divider between two requesters.
// DIVIDER_ZERO_BYPASS_EN: a zero divisor skips the calc phase (ACCEPT -> FINISH).
module divider_scheduler
   import divider_sched_pkg::*;
#(
   parameter int unsigned WIDTH = DefaultWidth
) (
   input  logic                clk,
   input  logic                rst_n,
   divider_scheduler_if.slave  bus,
   output logic                busy
);

   state_e             state_q, state_d;
   grant_e             grant_q, grant_d, last_grant_q, last_grant_d;
   logic               in_ack_a_q, in_ack_a_d, in_ack_b_q, in_ack_b_d;
   logic               out_stb_a_q, out_stb_a_d, out_stb_b_q, out_stb_b_d;
   logic [2*WIDTH-1:0] out_a_q, out_a_d, out_b_q, out_b_d;
   logic [2*WIDTH-1:0] sel_ops;
   logic               pick_a, core_done;
   logic [WIDTH-1:0]   quotient, remainder;

   assign sel_ops = (grant_q == GrantA) ? bus.input_a : bus.input_b;
   assign pick_a  = bus.input_a_stb && (!bus.input_b_stb || (last_grant_q == GrantB));

   serial_divider_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk         (clk),
      .rst_n       (rst_n),
      .start_i     (state_q == StAccept),
      .calc_i      (state_q == StCalc),
      .dividend_i  (sel_ops[2*WIDTH-1:WIDTH]),
      .divisor_i   (sel_ops[WIDTH-1:0]),
      .done_o      (core_done),
      .quotient_o  (quotient),
      .remainder_o (remainder)
   );

   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      in_ack_a_d   = 1'b0;
      in_ack_b_d   = 1'b0;
      out_stb_a_d  = out_stb_a_q;
      out_stb_b_d  = out_stb_b_q;
      out_a_d      = out_a_q;
      out_b_d      = out_b_q;
      unique case (state_q)
         StIdle: begin
            if (bus.input_a_stb || bus.input_b_stb) begin
               state_d    = StAccept;
               grant_d    = pick_a ? GrantA : GrantB;
               in_ack_a_d = pick_a;
               in_ack_b_d = !pick_a;
            end
         end
         StAccept: begin
            last_grant_d = grant_q;
`ifdef DIVIDER_ZERO_BYPASS_EN
            state_d = (sel_ops[WIDTH-1:0] == '0) ? StFinish : StCalc;
`else
            state_d = StCalc;
`endif
         end
         StCalc: begin
            if (core_done) state_d = StFinish;
         end
         StFinish: begin
            state_d = StResult;
            if (grant_q == GrantA) begin
               out_a_d     = {quotient, remainder};
               out_stb_a_d = 1'b1;
            end else begin
               out_b_d     = {quotient, remainder};
               out_stb_b_d = 1'b1;
            end
         end
         StResult: begin
            if ((out_stb_a_q && bus.output_a_ack) || (out_stb_b_q && bus.output_b_ack)) begin
               out_stb_a_d = 1'b0;
               out_stb_b_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         grant_q      <= GrantA;
         last_grant_q <= GrantB;
         in_ack_a_q   <= 1'b0;
         in_ack_b_q   <= 1'b0;
         out_stb_a_q  <= 1'b0;
         out_stb_b_q  <= 1'b0;
         out_a_q      <= '0;
         out_b_q      <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         in_ack_a_q   <= in_ack_a_d;
         in_ack_b_q   <= in_ack_b_d;
         out_stb_a_q  <= out_stb_a_d;
         out_stb_b_q  <= out_stb_b_d;
         out_a_q      <= out_a_d;
         out_b_q      <= out_b_d;
      end
   end

   assign bus.input_a_ack  = in_ack_a_q;
   assign bus.input_b_ack  = in_ack_b_q;
   assign bus.output_a_stb = out_stb_a_q;
   assign bus.output_b_stb = out_stb_b_q;
   assign bus.output_a     = out_a_q;
   assign bus.output_b     = out_b_q;
   assign busy             = (state_q != StIdle);

endmodule
